range_finder_p: RTL and testbench

Parametrised successor to the team's 8-bit range finder. Tracks running minimum, maximum and sample count of a WIDTH-bit stream between a go and a finish strobe, then reports range = max - min. Adds over the 8-bit version: configurable width, per-sample valid qualifier, min/max/count outputs, a done pulse, a saturating counter and a recoverable error state. Sits behind the tt_um top as the datapath for ui_in/uio_in control strobes.

---
 rtl/range_finder_pkg.sv | 20 ++
 rtl/range_finder_if.sv | 32 +++
 rtl/range_finder_minmax.sv | 74 +++++++
 rtl/range_finder_p.sv | 113 +++++++++++
 tb/tb_range_finder_p.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/range_finder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : range_finder_pkg
// Brief    : Shared state encoding for the range finder datapath.
// Revision : 1.0  initial release
// ============================================================================
package range_finder_pkg;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_COLLECT_ENC = 2'd1;
    localparam logic [1:0] ST_ERROR_ENC   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_COLLECT = ST_COLLECT_ENC,
        ST_ERROR   = ST_ERROR_ENC
    } state_t;

endpackage : range_finder_pkg
`default_nettype wire

// File: rtl/range_finder_if.sv
`default_nettype none
// ============================================================================
// Module   : range_finder_if
// Brief    : Sample stream, control strobes and result bus of the range finder.
// Revision : 1.0  initial release
// ============================================================================
interface range_finder_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] range;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             error;

    modport master (
        output data_in, in_valid, go, finish,
        input  range, min_val, max_val, count, done, error
    );

    modport slave (
        input  data_in, in_valid, go, finish,
        output range, min_val, max_val, count, done, error
    );
endinterface : range_finder_if
`default_nettype wire

// File: rtl/range_finder_minmax.sv
`default_nettype none
// ============================================================================
// Module   : range_finder_minmax
// Brief    : Running min/max/count accumulator; next_* include this cycle's
//            sample so the caller can latch a completed run on the same edge.
//            Signed compares when RANGE_FINDER_SIGNED_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module range_finder_minmax #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic             update,
    input  wire logic             sample_valid,
    input  wire logic [WIDTH-1:0] data,
    output logic      [WIDTH-1:0] next_min,
    output logic      [WIDTH-1:0] next_max,
    output logic      [CNT_W-1:0] next_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [CNT_W-1:0] r_cnt;
    logic             w_below_min;
    logic             w_above_max;

`ifdef RANGE_FINDER_SIGNED_EN
    assign w_below_min = $signed(data) < $signed(r_min);
    assign w_above_max = $signed(data) > $signed(r_max);
`else
    assign w_below_min = data < r_min;
    assign w_above_max = data > r_max;
`endif

    always_comb begin
        next_min = r_min;
        next_max = r_max;
        next_cnt = r_cnt;
        if (load) begin
            next_min = data;
            next_max = data;
            next_cnt = CNT_W'(sample_valid);
        end else if (update && sample_valid) begin
            // An empty run has no meaningful extremes yet, so seed from this sample
            if (r_cnt == '0) begin
                next_min = data;
                next_max = data;
            end else begin
                if (w_below_min) next_min = data;
                if (w_above_max) next_max = data;
            end
            if (r_cnt != CNT_MAX) next_cnt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min <= '0;
            r_max <= '0;
            r_cnt <= '0;
        end else begin
            r_min <= next_min;
            r_max <= next_max;
            r_cnt <= next_cnt;
        end
    end

endmodule : range_finder_minmax
`default_nettype wire

// File: rtl/range_finder_p.sv
`default_nettype none
// ============================================================================
// Module   : range_finder_p
// Brief    : Go/finish framed min/max/range/count tracker with error recovery.
//            Optional signed mode via RANGE_FINDER_SIGNED_EN.
// Revision : 1.0  initial release
// ============================================================================
module range_finder_p
    import range_finder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    range_finder_if.slave   bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_range;
    logic [WIDTH-1:0] r_min_val;
    logic [WIDTH-1:0] r_max_val;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_error;

    logic             w_load;
    logic             w_update;
    logic [WIDTH-1:0] w_next_min;
    logic [WIDTH-1:0] w_next_max;
    logic [CNT_W-1:0] w_next_cnt;

    assign w_load   = (r_state != ST_COLLECT) && bus.go && !bus.finish;
    assign w_update = (r_state == ST_COLLECT) && !bus.go;

    range_finder_minmax #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_minmax (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (w_load),
        .update       (w_update),
        .sample_valid (bus.in_valid),
        .data         (bus.data_in),
        .next_min     (w_next_min),
        .next_max     (w_next_max),
        .next_cnt     (w_next_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_range   <= '0;
            r_min_val <= '0;
            r_max_val <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.finish) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end else if (bus.go) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.go) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end else if (bus.finish) begin
                        // Latch from next_* so the finish-cycle sample is included
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_count <= w_next_cnt;
                        if (w_next_cnt == '0) begin
                            r_range   <= '0;
                            r_min_val <= '0;
                            r_max_val <= '0;
                        end else begin
                            r_range   <= w_next_max - w_next_min;
                            r_min_val <= w_next_min;
                            r_max_val <= w_next_max;
                        end
                    end
                end
                ST_ERROR: begin
                    if (bus.go && !bus.finish) begin
                        r_state <= ST_COLLECT;
                        r_error <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_error <= 1'b0;
                end
            endcase
        end
    end

    assign bus.range   = r_range;
    assign bus.min_val = r_min_val;
    assign bus.max_val = r_max_val;
    assign bus.count   = r_count;
    assign bus.done    = r_done;
    assign bus.error   = r_error;

endmodule : range_finder_p
`default_nettype wire

// File: tb/tb_range_finder_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_finder_p
// Brief    : Directed and random stimulus against a sample-list reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_range_finder_p;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    range_finder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    range_finder_p #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: membership in a run, error flag, and the list of samples
    bit               m_run;
    bit               m_err;
    logic [WIDTH-1:0] m_samples[$];
    logic [WIDTH-1:0] e_range, e_min, e_max;
    logic [CNT_W-1:0] e_count;
    logic             e_done;

    function automatic bit lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_FINDER_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".done"},  32'(bus.done),    32'(e_done));
        check({ctx, ".error"}, 32'(bus.error),   32'(m_err));
        check({ctx, ".range"}, 32'(bus.range),   32'(e_range));
        check({ctx, ".min"},   32'(bus.min_val), 32'(e_min));
        check({ctx, ".max"},   32'(bus.max_val), 32'(e_max));
        check({ctx, ".count"}, 32'(bus.count),   32'(e_count));
    endtask

    task automatic close_run();
        int n = m_samples.size();
        logic [WIDTH-1:0] lo, hi;
        e_done  = 1'b1;
        e_count = CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
        if (n == 0) begin
            e_min = '0; e_max = '0; e_range = '0;
        end else begin
            lo = m_samples[0];
            hi = m_samples[0];
            foreach (m_samples[i]) begin
                if (lt(m_samples[i], lo)) lo = m_samples[i];
                if (lt(hi, m_samples[i])) hi = m_samples[i];
            end
            e_min   = lo;
            e_max   = hi;
            e_range = hi - lo;
        end
    endtask

    task automatic cyc(input string ctx, input logic g, input logic f,
                       input logic v, input logic [WIDTH-1:0] d);
        bus.go = g; bus.finish = f; bus.in_valid = v; bus.data_in = d;
        e_done = 1'b0;
        if (!m_run) begin
            if (g && !f) begin
                m_run = 1'b1;
                m_err = 1'b0;
                m_samples.delete();
                if (v) m_samples.push_back(d);
            end else if (f) begin
                m_err = 1'b1;
            end
        end else if (g) begin
            m_run = 1'b0;
            m_err = 1'b1;
        end else begin
            if (v) m_samples.push_back(d);
            if (f) begin
                m_run = 1'b0;
                close_run();
            end
        end
        @(posedge clk);
        #1;
        check_outputs(ctx);
    endtask

    task automatic do_reset(input string ctx);
        rst_n = 1'b0;
        bus.go = 1'($urandom_range(0, 1));
        bus.finish = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
        bus.data_in = WIDTH'($urandom);
        m_run = 1'b0; m_err = 1'b0; m_samples.delete();
        e_range = '0; e_min = '0; e_max = '0; e_count = '0; e_done = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(ctx);
        rst_n = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] pick_data();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'(1 << (WIDTH - 1));
            3:       return WIDTH'((1 << (WIDTH - 1)) - 1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        bus.go = 1'b0; bus.finish = 1'b0; bus.in_valid = 1'b0; bus.data_in = '0;
        do_reset("reset");

        cyc("basic.go",   1, 0, 1, 8'd50);
        cyc("basic.s1",   0, 0, 1, 8'd10);
        cyc("basic.s2",   0, 0, 1, 8'd200);
        cyc("basic.s3",   0, 0, 1, 8'd90);
        cyc("basic.fin",  0, 1, 1, 8'd120);
        cyc("basic.post", 0, 0, 0, 8'd0);

        cyc("gofin_idle", 1, 1, 1, 8'd3);
        cyc("recov.go",   1, 0, 1, 8'd7);
        cyc("recov.fin",  0, 1, 1, 8'd7);

        cyc("coll.go",    1, 0, 1, 8'd5);
        cyc("coll.go2",   1, 0, 1, 8'd6);
        cyc("err.fin",    0, 1, 0, 8'd0);
        cyc("err.hold",   0, 0, 1, 8'd1);
        cyc("empty.go",   1, 0, 0, 8'd0);
        cyc("empty.fin",  0, 1, 0, 8'd0);
        cyc("idle.fin",   0, 1, 1, 8'd9);

        cyc("sat.go", 1, 0, 1, pick_data());
        for (int i = 0; i < 18; i++) cyc("sat.s", 0, 0, 1, pick_data());
        cyc("sat.fin", 0, 1, 1, pick_data());

        cyc("mid.go", 1, 0, 1, 8'd44);
        cyc("mid.s",  0, 0, 1, 8'd3);
        do_reset("mid.reset");
        cyc("mid.post", 0, 0, 0, 8'd0);

        cyc("ext.go",  1, 0, 1, 8'h80);
        cyc("ext.fin", 0, 1, 1, 8'h7F);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset("rand.reset");
            end else begin
                cyc("rand",
                    1'($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 3) != 0),
                    pick_data());
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_range_finder_p
`default_nettype wire
